// File: rtl/mac_tx_arbiter_pkg.sv
// mac_tx_pkg: shared types and Ethernet constants for the MAC TX arbiter.
//   state_t          - arbiter FSM states
//   ETH_MIN_PAYLOAD  - minimum frame bytes before CRC (64 minus 4-byte FCS)
//   ETH_IFG_BYTES    - standard inter-frame gap in byte times
package mac_tx_pkg;

    typedef enum logic [2:0] {
        S_RESET,
        S_IDLE,
        S_FRAME,
        S_PAD,
        S_GAP
    } state_t;

    localparam int ETH_MIN_PAYLOAD = 60;
    localparam int ETH_IFG_BYTES   = 12;

endpackage

// File: rtl/mac_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req       - request vector, one bit per port
//   last      - index of the most recently granted port
//   grant     - one-hot grant of the first requester after 'last' (wrapping)
//   grant_idx - binary index of that port
//   found     - at least one request present
// The pointer register lives in the parent so it can be updated only when a
// grant is actually taken.
module rr_arbiter
    import mac_tx_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 found
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        // NOTE: every output gets a default before the loop so no path
        // leaves it unassigned, which would infer a latch.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        // Scan last+1, last+2, ... wrapping; the first hit wins.
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = IDX_W'((int'(last) + k) % NUM_PORTS);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: frame-granular round-robin arbiter sharing one 8-bit
// AXI-Stream MAC TX path between NUM_PORTS frame sources.
//   clock, aresetn        - clock, synchronous active-low reset
//   saxis_t*              - per-port input streams (port i data at [8i+7:8i])
//   maxis_t*              - merged output stream toward the CRC stage
//   grant_id              - currently / last granted port
//   busy                  - high while a frame, pad or gap is in progress
// Build option: define TX_PAD_EN to pad short frames with 0x00 bytes up to
// MIN_FRAME_BYTES; without it tlast always passes straight through.
// Control is registered; the data path is a combinational mux of the
// granted port, so a stalled output holds whatever the source holds.
module mac_tx_arbiter
    import mac_tx_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int IFG_CYCLES      = ETH_IFG_BYTES,
    parameter int MIN_FRAME_BYTES = ETH_MIN_PAYLOAD
) (
    input  logic                         clock,
    input  logic                         aresetn,
    input  logic [NUM_PORTS*8-1:0]       saxis_tdata,
    input  logic [NUM_PORTS-1:0]         saxis_tvalid,
    output logic [NUM_PORTS-1:0]         saxis_tready,
    input  logic [NUM_PORTS-1:0]         saxis_tlast,
    input  logic [NUM_PORTS-1:0]         saxis_tuser,
    output logic [7:0]                   maxis_tdata,
    output logic                         maxis_tvalid,
    input  logic                         maxis_tready,
    output logic                         maxis_tlast,
    output logic                         maxis_tuser,
    output logic [$clog2(NUM_PORTS)-1:0] grant_id,
    output logic                         busy
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam state_t S_AFTER = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;

    state_t               state, state_n;
    logic [IDX_W-1:0]     last_grant;
    logic [NUM_PORTS-1:0] grant_sel;
    logic [GAP_W-1:0]     gap_cnt;

    logic [NUM_PORTS-1:0] arb_oh;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_found;

    logic [7:0] sel_data;
    logic       sel_valid, sel_last, sel_user;
    logic       pad_needed;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr (
        .req       (saxis_tvalid),
        .last      (last_grant),
        .grant     (arb_oh),
        .grant_idx (arb_idx),
        .found     (arb_found)
    );

    assign sel_data  = saxis_tdata[{grant_id, 3'b000} +: 8];
    assign sel_valid = saxis_tvalid[grant_id];
    assign sel_last  = saxis_tlast[grant_id];
    assign sel_user  = saxis_tuser[grant_id];

`ifdef TX_PAD_EN
    localparam int CNT_W = $clog2(MIN_FRAME_BYTES + 1);

    logic [CNT_W-1:0] byte_cnt;
    logic             tuser_sticky;
    logic             cnt_full;
    logic             pad_last;

    assign cnt_full   = (int'(byte_cnt) >= MIN_FRAME_BYTES);
    // byte_cnt counts beats already sent; the tlast beat itself makes +1.
    assign pad_needed = (int'(byte_cnt) + 1) < MIN_FRAME_BYTES;
    assign pad_last   = (int'(byte_cnt) == MIN_FRAME_BYTES - 1);

    always_ff @(posedge clock) begin
        if (!aresetn) begin
            byte_cnt     <= '0;
            tuser_sticky <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (arb_found) begin
                    byte_cnt     <= '0;
                    tuser_sticky <= 1'b0;
                end
                S_FRAME: if (sel_valid && maxis_tready) begin
                    if (!cnt_full) byte_cnt <= byte_cnt + 1'b1;
                    tuser_sticky <= tuser_sticky | sel_user;
                end
                S_PAD: if (maxis_tready) byte_cnt <= byte_cnt + 1'b1;
                default: ;
            endcase
        end
    end
`else
    assign pad_needed = 1'b0;
`endif

    // NOTE: reset is sampled on the clock edge only (synchronous), and all
    // state uses non-blocking assignment so every register sees the
    // pre-edge values of its neighbours.
    always_ff @(posedge clock) begin
        if (!aresetn) begin
            state      <= S_RESET;
            grant_id   <= '0;
            grant_sel  <= '0;
            last_grant <= IDX_W'(NUM_PORTS - 1);
            gap_cnt    <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && arb_found) begin
                grant_id   <= arb_idx;
                grant_sel  <= arb_oh;
                last_grant <= arb_idx;
            end
            // Load on entry so the gap lasts exactly IFG_CYCLES clocks.
            if (state_n == S_GAP && state != S_GAP)
                gap_cnt <= GAP_W'(IFG_CYCLES - 1);
            else if (state == S_GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
        end
    end

    always_comb begin
        state_n      = state;
        saxis_tready = '0;
        maxis_tdata  = '0;
        maxis_tvalid = 1'b0;
        maxis_tlast  = 1'b0;
        maxis_tuser  = 1'b0;
        busy         = 1'b0;
        case (state)
            S_RESET: state_n = S_IDLE;
            S_IDLE: if (arb_found) state_n = S_FRAME;
            S_FRAME: begin
                busy         = 1'b1;
                maxis_tdata  = sel_data;
                maxis_tvalid = sel_valid;
                maxis_tuser  = sel_user;
                maxis_tlast  = sel_valid & sel_last & ~pad_needed;
                saxis_tready = grant_sel & {NUM_PORTS{maxis_tready}};
                if (sel_valid && maxis_tready && sel_last)
                    state_n = pad_needed ? S_PAD : S_AFTER;
            end
`ifdef TX_PAD_EN
            S_PAD: begin
                busy         = 1'b1;
                maxis_tvalid = 1'b1;
                maxis_tuser  = tuser_sticky;
                maxis_tlast  = pad_last;
                if (maxis_tready && pad_last) state_n = S_AFTER;
            end
`endif
            S_GAP: begin
                busy = 1'b1;
                if (gap_cnt == '0) state_n = S_IDLE;
            end
            default: state_n = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb_mac_tx_arbiter: randomized scoreboard bench for mac_tx_arbiter.
// Frames are queued per port; a reference model expands them (round-robin
// order, optional padding) into an expected beat queue that a monitor pops
// on every output handshake. Build option TX_PAD_EN must match the RTL build.
module tb_mac_tx_arbiter;
    import mac_tx_pkg::*;

    localparam int NP    = 2;
    localparam int IFG   = 12;
    localparam int MINB  = 60;
    localparam int IDX_W = $clog2(NP);

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        int         port;
    } beat_t;

    logic              clock;
    logic              aresetn;
    logic [NP*8-1:0]   s_data;
    logic [NP-1:0]     s_valid, s_ready, s_last, s_user;
    logic [7:0]        m_data;
    logic              m_valid, m_ready, m_last, m_user;
    logic [IDX_W-1:0]  grant_id;
    logic              busy;

    beat_t src_q [NP][$];
    beat_t mdl_q [NP][$];
    beat_t exp_q [$];

    int checks      = 0;
    int errors      = 0;
    int beats_seen  = 0;
    int m_last_gnt  = NP - 1;
    bit bubbles     = 0;
    bit rand_ready  = 0;

    mac_tx_arbiter #(
        .NUM_PORTS       (NP),
        .IFG_CYCLES      (IFG),
        .MIN_FRAME_BYTES (MINB)
    ) dut (
        .clock        (clock),
        .aresetn      (aresetn),
        .saxis_tdata  (s_data),
        .saxis_tvalid (s_valid),
        .saxis_tready (s_ready),
        .saxis_tlast  (s_last),
        .saxis_tuser  (s_user),
        .maxis_tdata  (m_data),
        .maxis_tvalid (m_valid),
        .maxis_tready (m_ready),
        .maxis_tlast  (m_last),
        .maxis_tuser  (m_user),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Queue one frame on port p. incr selects bytes 1,2,3,... else random.
    task automatic add_frame(input int p, input int len, input int user_idx, input bit incr);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = incr ? 8'(i + 1) : 8'($urandom);
            b.user = (i == user_idx);
            b.last = (i == len - 1);
            b.port = p;
            src_q[p].push_back(b);
            mdl_q[p].push_back(b);
        end
    endtask

    // Reference model: whole frames leave in round-robin order; short frames
    // are extended with zero bytes carrying the OR of the frame's user bits.
    task automatic run_model();
        beat_t b, e;
        int    p, n;
        bit    sticky, done;
        forever begin
            p = -1;
            for (int k = 1; k <= NP; k++) begin
                if (p < 0 && mdl_q[(m_last_gnt + k) % NP].size() > 0)
                    p = (m_last_gnt + k) % NP;
            end
            if (p < 0) break;
            m_last_gnt = p;
            n = 0;
            sticky = 0;
            done = 0;
            while (!done) begin
                b = mdl_q[p].pop_front();
                n++;
                sticky |= b.user;
                e = b;
                e.port = p;
                done = b.last;
`ifdef TX_PAD_EN
                if (b.last && n < MINB) e.last = 1'b0;
`endif
                exp_q.push_back(e);
            end
`ifdef TX_PAD_EN
            while (n < MINB) begin
                n++;
                e.data = 8'h00;
                e.user = sticky;
                e.last = (n == MINB);
                e.port = p;
                exp_q.push_back(e);
            end
`endif
        end
    endtask

    function automatic bit src_pending();
        for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_pending() || busy) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check({name, "_done_in_budget"}, 32'(n < budget), 1);
        repeat (3) @(negedge clock);
    endtask

    // Source driver: one process for all ports; updates just after posedge.
    initial begin
        bit acc [NP];
        bit mid [NP];
        s_valid = '0;
        s_last  = '0;
        s_user  = '0;
        s_data  = '0;
        for (int p = 0; p < NP; p++) begin
            acc[p] = 0;
            mid[p] = 0;
        end
        forever begin
            @(posedge clock);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (acc[p] && src_q[p].size() > 0) begin
                    mid[p] = !src_q[p][0].last;
                    void'(src_q[p].pop_front());
                end
                if (src_q[p].size() == 0) begin
                    mid[p]           = 0;
                    s_valid[p]       = 1'b0;
                    s_last[p]        = 1'b0;
                    s_user[p]        = 1'b0;
                    s_data[8*p +: 8] = 8'h00;
                end else begin
                    // First beat of a frame is always presented so arbitration
                    // sees every waiting port; bubbles only inside a frame.
                    s_valid[p]       = (mid[p] && bubbles) ? ($urandom_range(0, 3) != 0) : 1'b1;
                    s_data[8*p +: 8] = src_q[p][0].data;
                    s_last[p]        = src_q[p][0].last;
                    s_user[p]        = src_q[p][0].user;
                end
            end
            @(negedge clock);
            for (int p = 0; p < NP; p++) acc[p] = s_valid[p] && s_ready[p];
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        bit         held, gap_run;
        logic [7:0] held_data;
        int         gap_cnt;
        beat_t      e;
        held = 0;
        gap_run = 0;
        held_data = '0;
        gap_cnt = 0;
        forever begin
            @(negedge clock);
            if (!aresetn) begin
                held = 0;
                gap_run = 0;
            end else begin
                if (gap_run) begin
                    if (busy) begin
                        gap_cnt++;
                        check("gap_tvalid_low", 32'(m_valid), 0);
                    end else begin
                        check("gap_length", gap_cnt, IFG);
                        gap_run = 0;
                    end
                end
                if (held && m_valid) check("tdata_held_while_stalled", 32'(m_data), 32'(held_data));
                held = m_valid && !m_ready;
                held_data = m_data;
                if (m_valid && m_ready) begin
                    beats_seen++;
                    check("beat_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("tdata", 32'(m_data), 32'(e.data));
                        check("tlast", 32'(m_last), 32'(e.last));
                        check("tuser", 32'(m_user), 32'(e.user));
                        check("grant_id", 32'(grant_id), e.port);
                    end
                    if (m_last) begin
                        gap_run = 1;
                        gap_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, 32'(m_valid), 0);
        check({tag, "_tdata"}, 32'(m_data), 0);
        check({tag, "_tlast"}, 32'(m_last), 0);
        check({tag, "_tuser"}, 32'(m_user), 0);
        check({tag, "_saxis_tready"}, 32'(s_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_grant_id"}, 32'(grant_id), 0);
    endtask

    initial begin
        int base, n;
        aresetn = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("por");
        @(posedge clock);
        #2 aresetn = 1'b1;
        repeat (2) @(negedge clock);

        // Single 64-byte frame from port 0, full throughput, then the gap.
        add_frame(0, 64, -1, 0);
        run_model();
        wait_done("frame64", 400);

        // Both ports continuously requesting, three frames each.
        for (int f = 0; f < 3; f++) begin
            add_frame(0, $urandom_range(8, 70), -1, 0);
            add_frame(1, $urandom_range(8, 70), -1, 0);
        end
        run_model();
        wait_done("rr_3x2", 2000);

        // Short frame 0x01..0x0A from port 1 (padded only with TX_PAD_EN).
        add_frame(1, 10, -1, 1);
        run_model();
        wait_done("short10", 400);

        // 100-byte frame under random back-pressure and source bubbles.
        rand_ready = 1;
        bubbles = 1;
        add_frame(0, 100, -1, 0);
        run_model();
        wait_done("backpressure100", 2000);
        rand_ready = 0;
        bubbles = 0;

        // Error flag on byte 3 of a 20-byte frame propagates into padding.
        add_frame(0, 20, 2, 0);
        run_model();
        wait_done("tuser20", 400);

        // Reset in the middle of a frame from port 0.
        add_frame(0, 64, -1, 0);
        run_model();
        base = beats_seen;
        n = 0;
        while (beats_seen < base + 30 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("reset_wait_in_budget", 32'(n < 200), 1);
        @(posedge clock);
        #2 aresetn = 1'b0;
        @(posedge clock);
        #2;
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            mdl_q[p].delete();
        end
        exp_q.delete();
        m_last_gnt = NP - 1;
        @(negedge clock);
        check_reset_outputs("midframe_reset");
        @(posedge clock);
        #2 aresetn = 1'b1;
        repeat (2) @(negedge clock);

        // After reset port 0 must win even though it held the last grant.
        add_frame(1, 16, -1, 0);
        add_frame(0, 16, -1, 0);
        run_model();
        wait_done("post_reset", 800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
